logic_unit_pipe: RTL and testbench

Parametrised, registered successor to the combinational gate selector. It applies one of eight bitwise logic operations to WIDTH-bit operands and can chain results through an internal accumulator. Results are buffered in a DEPTH-entry output FIFO behind a valid/ready handshake. It sits between an operand producer and a result consumer, and can stall either side without losing data.

---
 rtl/logic_unit_pipe.sv | 121 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with an accumulator
// feedback path and a DEPTH-entry output FIFO behind a valid/ready handshake.

module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data1,
  input  logic [WIDTH-1:0]         data2,
  input  logic [2:0]               op_cntrl,
  input  logic                     acc_mode,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Each FIFO entry carries the result with its zero flag in the top bit.
  logic [WIDTH:0]    mem_q [DEPTH];
  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  acc_q, acc_d;

  logic [WIDTH-1:0]  opB;
  logic [WIDTH-1:0]  result;
  logic              accept;
  logic              pop;
  logic [WIDTH:0]    head;

  // Second operand: data2 normally, the accumulator in chaining mode,
  // with a same-cycle clear forcing zero so clear-then-operate works.
  always_comb begin
    opB = data2;
    if (acc_mode) begin
      opB = acc_clr ? '0 : acc_q;
    end
  end

  // Operation decode; every code maps to a defined function.
  always_comb begin
    result = '0;
    unique case (op_cntrl)
      3'b000:  result = data1 & opB;
      3'b001:  result = data1 | opB;
      3'b010:  result = ~data1;
      3'b011:  result = ~(data1 & opB);
      3'b100:  result = ~(data1 | opB);
      3'b101:  result = data1 ^ opB;
      3'b110:  result = ~(data1 ^ opB);
      default: result = opB;
    endcase
  end

  assign in_ready  = Enable && !rst && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rdPtr_q];
  assign out       = out_valid ? head[WIDTH-1:0] : '0;
  assign out_zero  = out_valid ? head[WIDTH] : 1'b0;
  assign count     = count_q;

  // Pointer, occupancy and accumulator next-state; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    acc_d   = acc_q;
    if (accept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (accept && acc_mode) begin
      acc_d = result;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  // Control state register; reset empties the FIFO and clears the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  // FIFO storage; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wrPtr_q] <= {(result == '0), result};
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vectors with a scoreboard queue; the driver
// pushes expected results on accept, an independent monitor pops on each pop.

module tb_logic_unit_pipe;

  localparam int W = 8;
  localparam int D = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            Enable;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    data1;
  logic [W-1:0]    data2;
  logic [2:0]      op_cntrl;
  logic            acc_mode;
  logic            acc_clr;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out;
  logic            out_zero;
  logic [$clog2(D):0] count;

  int checks = 0;
  int errors = 0;
  logic [W:0] expQ [$];

  logic [W-1:0] opExp [8];

  logic_unit_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .Enable(Enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .op_cntrl(op_cntrl),
    .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_zero(out_zero), .count(count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand set, wait (bounded) for acceptance, record expectation.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic am, input logic clr,
                               input logic [W-1:0] exp);
    bit done = 0;
    Enable   = 1'b1;
    in_valid = 1'b1;
    data1    = a;
    data2    = b;
    op_cntrl = op;
    acc_mode = am;
    acc_clr  = clr;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back({(exp == '0), exp});
        done = 1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %0b expected 1", in_ready);
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    acc_mode = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && expQ.size() != 0; i++) tick();
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  // Monitor: every handshake pop is compared against the scoreboard head.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0h expected none", out);
        end else begin
          e = expQ.pop_front();
          checkOutput("out", out, e[W-1:0]);
          checkOutput("out_zero", out_zero, e[W]);
        end
      end
    end
  end

  initial begin
    opExp[0] = 8'h30; opExp[1] = 8'hFC; opExp[2] = 8'h0F; opExp[3] = 8'hCF;
    opExp[4] = 8'h03; opExp[5] = 8'hCC; opExp[6] = 8'h33; opExp[7] = 8'h3C;

    rst = 1'b1; Enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data1 = '0; data2 = '0; op_cntrl = '0; acc_mode = 1'b0; acc_clr = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out", out, 0);
    checkOutput("rst_out_zero", out_zero, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    tick();

    // All eight operations back to back, one-cycle latency each.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0, opExp[i]);
      checkOutput("latency_valid", out_valid, 1);
    end
    applyStimulus(8'hAA, 8'hAA, 3'b101, 1'b0, 1'b0, 8'h00);
    waitDrain();

    // Clear with a non-accumulating accept still uses data2.
    applyStimulus(8'h0F, 8'hF0, 3'b000, 1'b0, 1'b1, 8'h00);
    // Accumulator chaining.
    applyStimulus(8'h01, 8'hFF, 3'b001, 1'b1, 1'b1, 8'h01);
    applyStimulus(8'h02, 8'hFF, 3'b001, 1'b1, 1'b0, 8'h03);
    applyStimulus(8'h01, 8'hFF, 3'b101, 1'b1, 1'b0, 8'h02);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    applyStimulus(8'h33, 8'h77, 3'b111, 1'b1, 1'b0, 8'h00);
    waitDrain();

    // Backpressure: two accepted, third held off until a pop.
    out_ready = 1'b0;
    applyStimulus(8'h00, 8'h11, 3'b111, 1'b0, 1'b0, 8'h11);
    applyStimulus(8'h00, 8'h22, 3'b111, 1'b0, 1'b0, 8'h22);
    in_valid = 1'b1; data2 = 8'h33; op_cntrl = 3'b111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("full_in_ready", in_ready, 0);
      checkOutput("full_count", count, 2);
      checkOutput("full_head_stable", out, 8'h11);
      tick();
    end
    out_ready = 1'b1;
    applyStimulus(8'h00, 8'h33, 3'b111, 1'b0, 1'b0, 8'h33);
    waitDrain();

    // Enable low closes the input while the FIFO still drains.
    out_ready = 1'b0;
    applyStimulus(8'h00, 8'h5A, 3'b111, 1'b0, 1'b0, 8'h5A);
    Enable = 1'b0; in_valid = 1'b1; data2 = 8'h77;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("disabled_in_ready", in_ready, 0);
      checkOutput("disabled_count", count, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("disabled_drained_count", count, 0);
    checkOutput("disabled_drained_valid", out_valid, 0);
    checkOutput("disabled_drained_out", out, 0);
    in_valid = 1'b0; Enable = 1'b1;
    tick();

    // Mid-stream reset discards the entry and clears the accumulator.
    out_ready = 1'b0;
    applyStimulus(8'h5A, 8'h00, 3'b001, 1'b1, 1'b1, 8'h5A);
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out", out, 0);
    checkOutput("midrst_out_zero", out_zero, 0);
    checkOutput("midrst_in_ready_after", in_ready, 1);
    tick();
    out_ready = 1'b1;
    applyStimulus(8'h0F, 8'h00, 3'b001, 1'b1, 1'b0, 8'h0F);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
